sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
Parametrised successor to the rocket left/right mover. Owns one sprite's position and issues the pixel stream that erases and redraws it on the VGA adapter. Sprite size, step, screen size, start position, ROM read latency and edge policy are parameters, so one block serves the rocket, invaders and mothership. Sits between the game FSM (commands) and the VGA adapter / sprite ROM.

Parameters:
X_SCREEN_PIXELS, 160, screen width
Y_SCREEN_PIXELS, 120, screen height
SPRITE_W, 11, sprite width in pixels
SPRITE_H, 10, sprite height in pixels
X_START, 73, initial/reset x of sprite top-left
Y_START, 105, fixed y of sprite top-left
STEP, 5, pixels moved per command
ROM_LATENCY, 1, sprite ROM address-to-data cycles (1..3)
EDGE_MODE, 0, 0 = clamp at edge, 1 = refuse move and pulse hitEdge
AW, 7, ROM address width; must satisfy 2^AW >= SPRITE_W*SPRITE_H

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low; clears all state
start  in  1  request initial draw at current position
left  in  1  request move left by STEP
right  in  1  request move right by STEP
romData  in  3  sprite ROM colour, valid ROM_LATENCY cycles after romAddr
romAddr  out  AW  sprite ROM address, row-major (row*SPRITE_W + col)
xout  out  8  pixel x to VGA
yout  out  7  pixel y to VGA
colourOut  out  3  pixel colour to VGA
drawEn  out  1  pixel write strobe
busy  out  1  high while CLEAR or DRAW in progress
done  out  1  one-cycle pulse after the last pixel of a draw pass
hitEdge  out  1  one-cycle pulse on a refused move (EDGE_MODE=1 only)
xPos  out  8  current sprite top-left x

Behaviour:
- Reset (async, active-low): state IDLE; xPos=X_START; xout=0, yout=0, colourOut=0, drawEn=0, busy=0, done=0, hitEdge=0, romAddr=0; coordinate pipeline flushed. Reset mid-pass aborts with no further drawEn.
- States: IDLE, CLEAR, DRAW, FLUSH.
- IDLE: commands sampled every cycle; priority start > single direction. left and right high in the same cycle = no action. All commands ignored while busy (no queueing).
- start in IDLE -> DRAW at xPos.
- left: target = xPos-STEP; if xPos < STEP: EDGE_MODE 0 -> target = 0; EDGE_MODE 1 -> hitEdge pulse, stay IDLE, no pixels. If target == xPos (already at 0) -> no action.
- right: limit XMAX = X_SCREEN_PIXELS-SPRITE_W; target = xPos+STEP; if target > XMAX: clamp to XMAX (mode 0) or hitEdge pulse, no pixels (mode 1). target == xPos -> no action.
- Accepted move: CLEAR at old xPos, then xPos <= target, then DRAW.
- CLEAR: SPRITE_W*SPRITE_H cycles, raster order (col fastest), colourOut=0, drawEn=1 every cycle, no ROM use.
- DRAW: romAddr steps 0..W*H-1 one per cycle; (x,y) delayed through a ROM_LATENCY-deep pipeline so xout/yout/colourOut=romData/drawEn are aligned; FLUSH drains the last ROM_LATENCY pixels. Pass length = W*H + ROM_LATENCY cycles; exactly W*H drawEn pulses. done pulses the cycle after the last drawEn; return to IDLE.
- Arithmetic in 9 bits before clamp; no wrap-around of xPos. Pixel x = xPos+col, y = Y_START+row, always on screen.
- busy high from the cycle after acceptance through the done cycle.

Decomposition:
- Shared package sprite_pkg: colour width (3), BLACK constant, screen dimension constants, edge-mode encodings.
- One sub-module: sprite_raster — col/row counters plus the ROM_LATENCY coordinate delay line; instantiated once, used for both CLEAR (latency bypassed) and DRAW.

Test Plan:
- Reset then start (defaults) -> 110 drawEn pulses covering x 73..83, y 105..114; colour = ROM contents; done one cycle after the last; xPos=73.
- From IDLE at 73, left -> 110 black pixels at x 73..83, then 110 sprite pixels at x 68..78; xPos=68; commands during busy ignored.
- xPos=147, right (mode 0) -> clamp, xPos=149; again right -> no pixels, no done. Mode 1 with xPos=3, left -> hitEdge pulse, zero drawEn, xPos=3.
- ROM_LATENCY=3 with romData = address[2:0] -> pixel (col,row) colour == (row*11+col) mod 8; 113-cycle draw pass.
- left and right together in IDLE -> no busy, no drawEn, xPos unchanged.
- Reset asserted at pixel 50 of a DRAW -> drawEn low immediately, xPos=73, state IDLE; subsequent start draws correctly.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour, screen, edge-mode and pixel types for the sprite movers
package sprite_pkg;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BLACK = '0;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  typedef enum int {EDGE_CLAMP = 0, EDGE_REFUSE = 1} edge_mode_t;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} state_t;
  typedef struct packed {
    logic valid;
    logic draw;
    logic [7:0] x;
    logic [6:0] y;
  } pixel_t;
endpackage

// File: rtl/sprite_raster.sv
// sprite_raster: col/row/address scan plus the ROM-latency coordinate delay line
module sprite_raster
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 11,
  parameter int SPRITE_H = 10,
  parameter int ROM_LATENCY = 1,
  parameter int AW = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  input  logic [7:0] xBase,
  input  logic [6:0] yBase,
  output logic [AW-1:0] addr,
  output logic last,
  output pixel_t pix
);
  localparam int CW = $clog2(SPRITE_W + 1);
  localparam int RW = $clog2(SPRITE_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t head;
  pixel_t [ROM_LATENCY-1:0] pipe, nxt;
  pixel_t [ROM_LATENCY:0] shifted;
  assign last = col == COL_LAST && row == ROW_LAST;
  assign head = {run, !clear, xBase + 8'(col), yBase + 7'(row)};
  assign shifted = {pipe, head};
  assign pix = pipe[ROM_LATENCY-1];
  // Clear pixels skip the ROM delay: they land straight in the output stage
  always_comb begin
    nxt = clear ? '0 : shifted[ROM_LATENCY-1:0];
    if (clear) nxt[ROM_LATENCY-1] = head;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
      addr <= '0;
      pipe <= '0;
    end else begin
      pipe <= nxt;
      if (run) begin
        col <= col == COL_LAST ? '0 : col + 1'b1;
        row <= col != COL_LAST ? row : row == ROW_LAST ? '0 : row + 1'b1;
        addr <= last ? '0 : addr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: owns one sprite's x position and streams its erase/redraw pixels to the VGA adapter
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int X_SCREEN_PIXELS = SCREEN_W,
  parameter int Y_SCREEN_PIXELS = SCREEN_H,
  parameter int SPRITE_W = 11,
  parameter int SPRITE_H = 10,
  parameter int X_START = 73,
  parameter int Y_START = 105,
  parameter int STEP = 5,
  parameter int ROM_LATENCY = 1,
  parameter int EDGE_MODE = 0,
  parameter int AW = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic left,
  input  logic right,
  input  logic [COLOUR_W-1:0] romData,
  output logic [AW-1:0] romAddr,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic [COLOUR_W-1:0] colourOut,
  output logic drawEn,
  output logic busy,
  output logic done,
  output logic hitEdge,
  output logic [7:0] xPos
);
  localparam int XMAX = X_SCREEN_PIXELS - SPRITE_W;
  localparam int Y_TOP = Y_START + SPRITE_H > Y_SCREEN_PIXELS ? Y_SCREEN_PIXELS - SPRITE_H : Y_START;
  localparam bit REFUSE = EDGE_MODE == EDGE_REFUSE;
  state_t state;
  pixel_t pix;
  logic [7:0] target, leftNext, rightNext;
  logic [8:0] x9, rightTgt;
  logic [1:0] flushCnt;
  logic rasterLast, leftUnder, rightOver, goLeft, goRight;
  assign x9 = {1'b0, xPos};
  assign rightTgt = x9 + 9'(STEP);
  assign leftUnder = x9 < 9'(STEP);
  assign rightOver = rightTgt > 9'(XMAX);
  assign leftNext = leftUnder ? '0 : 8'(x9 - 9'(STEP));
  assign rightNext = rightOver ? 8'(XMAX) : rightTgt[7:0];
  assign goLeft = left && !right;
  assign goRight = right && !left;
  assign xout = pix.x;
  assign yout = pix.y;
  assign drawEn = pix.valid;
  assign colourOut = pix.valid && pix.draw ? romData : BLACK;
  sprite_raster #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ROM_LATENCY(ROM_LATENCY), .AW(AW)
  ) raster (
    .clk(clk), .reset(reset),
    .run(state == CLEAR || state == DRAW), .clear(state == CLEAR),
    .xBase(xPos), .yBase(7'(Y_TOP)),
    .addr(romAddr), .last(rasterLast), .pix(pix)
  );
  // busy stays high through the done cycle, so IDLE with busy set just retires the pass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      xPos <= 8'(X_START);
      target <= 8'(X_START);
      flushCnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hitEdge <= 1'b0;
    end else begin
      done <= 1'b0;
      hitEdge <= 1'b0;
      case (state)
        IDLE:
          if (busy) busy <= 1'b0;
          else if (start) begin
            state <= DRAW;
            busy <= 1'b1;
          end else if (goLeft) begin
            if (leftUnder && REFUSE) hitEdge <= 1'b1;
            else if (leftNext != xPos) begin
              state <= CLEAR;
              busy <= 1'b1;
              target <= leftNext;
            end
          end else if (goRight) begin
            if (rightOver && REFUSE) hitEdge <= 1'b1;
            else if (rightNext != xPos) begin
              state <= CLEAR;
              busy <= 1'b1;
              target <= rightNext;
            end
          end
        CLEAR:
          if (rasterLast) begin
            state <= DRAW;
            xPos <= target;
          end
        DRAW:
          if (rasterLast) begin
            state <= FLUSH;
            flushCnt <= '0;
          end
        FLUSH:
          if (flushCnt == 2'(ROM_LATENCY - 1)) begin
            state <= IDLE;
            done <= 1'b1;
          end else flushCnt <= flushCnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed checks of three sprite_mover configurations (default, latency 3, refuse mode)
module tb_sprite_mover;
  logic clk = 1'b0, reset = 1'b0;
  logic [2:0] start = '0, left = '0, right = '0;
  logic [2:0] drawEn, busy, done, hitEdge;
  logic [6:0] romAddr [3];
  logic [7:0] xout [3];
  logic [7:0] xPos [3];
  logic [6:0] yout [3];
  logic [2:0] colourOut [3];
  logic [2:0] romData [3];
  logic [6:0] r1, r2;
  int nAssert = 0, nFail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    romData[0] <= 3'(romAddr[0] * 5 + 3);
    romData[2] <= 3'(romAddr[2] * 5 + 3);
    r1 <= romAddr[1];
    r2 <= r1;
    romData[1] <= r2[2:0];
  end

  sprite_mover dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .left(left[0]), .right(right[0]),
    .romData(romData[0]), .romAddr(romAddr[0]), .xout(xout[0]), .yout(yout[0]),
    .colourOut(colourOut[0]), .drawEn(drawEn[0]), .busy(busy[0]), .done(done[0]),
    .hitEdge(hitEdge[0]), .xPos(xPos[0]));

  sprite_mover #(.X_START(147), .ROM_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .left(left[1]), .right(right[1]),
    .romData(romData[1]), .romAddr(romAddr[1]), .xout(xout[1]), .yout(yout[1]),
    .colourOut(colourOut[1]), .drawEn(drawEn[1]), .busy(busy[1]), .done(done[1]),
    .hitEdge(hitEdge[1]), .xPos(xPos[1]));

  sprite_mover #(.X_START(3), .EDGE_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .left(left[2]), .right(right[2]),
    .romData(romData[2]), .romAddr(romAddr[2]), .xout(xout[2]), .yout(yout[2]),
    .colourOut(colourOut[2]), .drawEn(drawEn[2]), .busy(busy[2]), .done(done[2]),
    .hitEdge(hitEdge[2]), .xPos(xPos[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expCol(input int d, input int a);
    return d == 1 ? a % 8 : (a * 5 + 3) % 8;
  endfunction

  // Follows one accepted pass (optional clear, then draw) and checks every pixel and the timing
  task automatic watch(input int d, input int xClear, input int xDraw, input bit poke);
    int cyc, idx, bad, lastEn, doneAt, nc, lat, a, ex, ey, ec;
    cyc = 0; idx = 0; bad = 0; lastEn = -1; doneAt = -1;
    lat = d == 1 ? 3 : 1;
    nc = xClear >= 0 ? 110 : 0;
    while (doneAt < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start[d] = 1'b0; left[d] = 1'b0; right[d] = 1'b0;
        check("busyAfterAccept", busy[d], 1);
      end
      if (poke) begin
        left[d] = cyc == 20;
        right[d] = cyc == 40;
        start[d] = cyc == 60;
      end
      if (drawEn[d]) begin
        a = idx < nc ? idx : idx - nc;
        ex = (idx < nc ? xClear : xDraw) + a % 11;
        ey = 105 + a / 11;
        ec = idx < nc ? 0 : expCol(d, a);
        if (xout[d] !== 8'(ex) || yout[d] !== 7'(ey) || colourOut[d] !== 3'(ec)) bad++;
        idx++;
        lastEn = cyc;
      end
      if (done[d]) doneAt = cyc;
    end
    start[d] = 1'b0; left[d] = 1'b0; right[d] = 1'b0;
    check("pixelCount", idx, nc + 110);
    check("pixelErrors", bad, 0);
    check("doneAfterLast", doneAt - lastEn, 1);
    check("passLength", doneAt, nc + 110 + lat + 1);
    @(negedge clk);
    check("busyDropped", busy[d], 0);
    check("xPosAfter", xPos[d], xDraw);
  endtask

  // Issues a command that must not start a pass; counts any activity for a few cycles
  task automatic idleCmd(input int d, input bit l, input bit r, input int expHit, input int expX);
    int en, bz, dn, hit;
    en = 0; bz = 0; dn = 0; hit = 0;
    @(negedge clk);
    left[d] = l; right[d] = r;
    repeat (6) begin
      @(negedge clk);
      left[d] = 1'b0; right[d] = 1'b0;
      en += int'(drawEn[d]); bz += int'(busy[d]); dn += int'(done[d]); hit += int'(hitEdge[d]);
    end
    check("idleNoDrawEn", en, 0);
    check("idleNoBusy", bz, 0);
    check("idleNoDone", dn, 0);
    check("idleHitEdge", hit, expHit);
    check("idleXPos", xPos[d], expX);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, en;
    repeat (3) @(negedge clk);
    check("rstXout", xout[0], 0);
    check("rstYout", yout[0], 0);
    check("rstColour", colourOut[0], 0);
    check("rstDrawEn", drawEn[0], 0);
    check("rstBusy", busy[0], 0);
    check("rstDone", done[0], 0);
    check("rstHitEdge", hitEdge[0], 0);
    check("rstRomAddr", romAddr[0], 0);
    check("rstXPos0", xPos[0], 73);
    check("rstXPos1", xPos[1], 147);
    check("rstXPos2", xPos[2], 3);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    @(negedge clk); start[0] = 1'b1; watch(0, -1, 73, 0);
    @(negedge clk); left[0] = 1'b1; watch(0, 73, 68, 1);
    idleCmd(0, 1'b1, 1'b1, 0, 68);

    @(negedge clk); start[1] = 1'b1; watch(1, -1, 147, 0);
    @(negedge clk); right[1] = 1'b1; watch(1, 147, 149, 0);
    idleCmd(1, 1'b0, 1'b1, 0, 149);

    idleCmd(2, 1'b1, 1'b0, 1, 3);
    @(negedge clk); right[2] = 1'b1; watch(2, 3, 8, 0);

    @(negedge clk); start[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 50; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (drawEn[0]) cnt++;
    end
    check("reachedPixel50", cnt, 50);
    reset = 1'b0;
    #1;
    check("midResetDrawEn", drawEn[0], 0);
    check("midResetBusy", busy[0], 0);
    check("midResetXPos", xPos[0], 73);
    check("midResetColour", colourOut[0], 0);
    @(negedge clk); reset = 1'b1;
    en = 0;
    repeat (5) begin
      @(negedge clk);
      en += int'(drawEn[0]) + int'(busy[0]);
    end
    check("postResetQuiet", en, 0);
    @(negedge clk); start[0] = 1'b1; watch(0, -1, 73, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
